// File: rtl/pcs_tx_pkt_gen.sv
// Back-to-back Ethernet frame source for the TX PCS input interface.
// Deterministic payload (seed+index) so a far-end checker can verify each byte.
module pcs_tx_pkt_gen #(
  parameter int DATA_W      = 64,
  parameter int LANE0_CNT_N = 2,
  parameter int IFG_BEATS   = 2,
  parameter int LEN_W       = 11,
  localparam int KEEP_W     = DATA_W / 8
) (
  input  logic                   tx_clk,
  input  logic                   tx_reset,
  input  logic                   en_i,
  input  logic [LEN_W-1:0]       cfg_len_i,
  input  logic                   cfg_err_i,
  input  logic                   pcs_tx_ready_i,
  output logic                   pcs_tx_ctrl_o,
  output logic                   pcs_tx_idle_o,
  output logic                   pcs_tx_term_o,
  output logic                   pcs_tx_err_o,
  output logic [LANE0_CNT_N-1:0] pcs_tx_start_o,
  output logic [DATA_W-1:0]      pcs_tx_data_o,
  output logic [KEEP_W-1:0]      pcs_tx_keep_o,
  output logic [31:0]            frame_cnt_o
);

  localparam int GAP_W = $clog2(IFG_BEATS + 1);
  localparam logic [DATA_W-1:0] SFD_BEAT = DATA_W'(64'hD555_5555_5555_55FB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_TERM
  } state_t;

  state_t                   state, state_n;
  logic [GAP_W-1:0]         gap, gap_n, gap_dec;
  logic [LEN_W-1:0]         len_lat, len_n;
  logic [LEN_W-1:0]         k, k_n, rem;
  logic                     err_lat, err_n;
  logic [7:0]               seed, seed_n, base;
  logic [31:0]              cnt_n;
  logic                     ctrl_n, idle_n, term_n, oerr_n;
  logic [LANE0_CNT_N-1:0]   start_n;
  logic [DATA_W-1:0]        data_n, pay;
  logic [KEEP_W-1:0]        keep_n, tail_mask;

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state          <= S_IDLE;
      gap            <= GAP_W'(IFG_BEATS);
      len_lat        <= '0;
      k              <= '0;
      err_lat        <= 1'b0;
      seed           <= '0;
      frame_cnt_o    <= '0;
      pcs_tx_ctrl_o  <= 1'b1;
      pcs_tx_idle_o  <= 1'b1;
      pcs_tx_term_o  <= 1'b0;
      pcs_tx_err_o   <= 1'b0;
      pcs_tx_start_o <= '0;
      pcs_tx_data_o  <= '0;
      pcs_tx_keep_o  <= '0;
    end else begin
      state          <= state_n;
      gap            <= gap_n;
      len_lat        <= len_n;
      k              <= k_n;
      err_lat        <= err_n;
      seed           <= seed_n;
      frame_cnt_o    <= cnt_n;
      pcs_tx_ctrl_o  <= ctrl_n;
      pcs_tx_idle_o  <= idle_n;
      pcs_tx_term_o  <= term_n;
      pcs_tx_err_o   <= oerr_n;
      pcs_tx_start_o <= start_n;
      pcs_tx_data_o  <= data_n;
      pcs_tx_keep_o  <= keep_n;
    end
  end

  // k counts payload bytes already emitted; the next beat starts at seed+k
  always_comb begin
    rem       = len_lat - k;
    base      = seed + k[7:0];
    tail_mask = ~({KEEP_W{1'b1}} << rem[2:0]);
    gap_dec   = (gap != '0) ? gap - 1'b1 : '0;
    pay       = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      pay[j*8 +: 8] = base + 8'(j);
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap;
    len_n   = len_lat;
    k_n     = k;
    err_n   = err_lat;
    seed_n  = seed;
    cnt_n   = frame_cnt_o;
    ctrl_n  = pcs_tx_ctrl_o;
    idle_n  = pcs_tx_idle_o;
    term_n  = pcs_tx_term_o;
    oerr_n  = pcs_tx_err_o;
    start_n = pcs_tx_start_o;
    data_n  = pcs_tx_data_o;
    keep_n  = pcs_tx_keep_o;
    if (pcs_tx_ready_i) begin
      unique case (state)
        S_IDLE: begin
          gap_n = gap_dec;
          if (gap_dec == '0 && en_i) begin
            state_n = S_START;
            ctrl_n  = 1'b1;
            idle_n  = 1'b0;
            start_n = LANE0_CNT_N'(1);
            data_n  = SFD_BEAT;
            keep_n  = '1;
            len_n   = cfg_len_i;
            err_n   = cfg_err_i;
            k_n     = '0;
          end
        end
        S_START, S_DATA: begin
          idle_n  = 1'b0;
          start_n = '0;
          if (rem >= LEN_W'(8)) begin
            state_n = S_DATA;
            ctrl_n  = 1'b0;
            keep_n  = '1;
            data_n  = pay;
            k_n     = k + LEN_W'(8);
          end else begin
            state_n = S_TERM;
            ctrl_n  = 1'b1;
            term_n  = 1'b1;
            oerr_n  = err_lat;
            keep_n  = tail_mask;
            for (int j = 0; j < KEEP_W; j++) begin
              data_n[j*8 +: 8] = tail_mask[j] ? pay[j*8 +: 8] : 8'h00;
            end
          end
        end
        S_TERM: begin
          state_n = S_IDLE;
          gap_n   = GAP_W'(IFG_BEATS);
          seed_n  = seed + 8'd1;
          cnt_n   = frame_cnt_o + 32'd1;
          ctrl_n  = 1'b1;
          idle_n  = 1'b1;
          term_n  = 1'b0;
          oerr_n  = 1'b0;
          start_n = '0;
          data_n  = '0;
          keep_n  = '0;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_pkt_gen.sv
// Scoreboard bench for pcs_tx_pkt_gen: model pushes expected beats,
// each accepted beat pops and compares; stalled beats are compared unpopped.
module tb_pcs_tx_pkt_gen;

  typedef logic [77:0] beat_t;
  localparam beat_t IDLE_B = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 64'h0};

  logic        tx_clk = 1'b0;
  logic        tx_reset = 1'b1;
  logic        en_i = 1'b0;
  logic [10:0] cfg_len_i = '0;
  logic        cfg_err_i = 1'b0;
  logic        pcs_tx_ready_i = 1'b1;
  logic        pcs_tx_ctrl_o, pcs_tx_idle_o, pcs_tx_term_o, pcs_tx_err_o;
  logic [1:0]  pcs_tx_start_o;
  logic [63:0] pcs_tx_data_o;
  logic [7:0]  pcs_tx_keep_o;
  logic [31:0] frame_cnt_o;

  beat_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_seed = '0;
  int          m_cnt = 0;

  pcs_tx_pkt_gen dut (
    .tx_clk         (tx_clk),
    .tx_reset       (tx_reset),
    .en_i           (en_i),
    .cfg_len_i      (cfg_len_i),
    .cfg_err_i      (cfg_err_i),
    .pcs_tx_ready_i (pcs_tx_ready_i),
    .pcs_tx_ctrl_o  (pcs_tx_ctrl_o),
    .pcs_tx_idle_o  (pcs_tx_idle_o),
    .pcs_tx_term_o  (pcs_tx_term_o),
    .pcs_tx_err_o   (pcs_tx_err_o),
    .pcs_tx_start_o (pcs_tx_start_o),
    .pcs_tx_data_o  (pcs_tx_data_o),
    .pcs_tx_keep_o  (pcs_tx_keep_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 tx_clk = ~tx_clk;

  function automatic beat_t beat_now();
    return {pcs_tx_ctrl_o, pcs_tx_idle_o, pcs_tx_term_o, pcs_tx_err_o,
            pcs_tx_start_o, pcs_tx_keep_o, pcs_tx_data_o};
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(IDLE_B);
  endtask

  task automatic push_frame(input int len, input bit e);
    int k;
    int r;
    logic [63:0] d;
    logic [7:0] kp;
    k = 0;
    sb.push_back({1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 8'hFF,
                  64'hD555_5555_5555_55FB});
    while (len - k >= 8) begin
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'((m_seed + k + j) % 256);
      sb.push_back({1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, d});
      k += 8;
    end
    r = len - k;
    d = '0;
    kp = '0;
    for (int j = 0; j < r; j++) begin
      d[j*8 +: 8] = 8'((m_seed + k + j) % 256);
      kp[j] = 1'b1;
    end
    sb.push_back({1'b1, 1'b0, 1'b1, e, 2'b00, kp, d});
    m_seed = m_seed + 8'd1;
    m_cnt++;
  endtask

  task automatic do_reset();
    @(negedge tx_clk);
    tx_reset = 1'b1;
    pcs_tx_ready_i = 1'b1;
    repeat (2) @(negedge tx_clk);
    tx_reset = 1'b0;
    sb.delete();
    m_seed = '0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    en_i = 1'b0;
    @(negedge tx_clk);
    tx_reset = 1'b1;
    @(negedge tx_clk);
    checks++;
    if (beat_now() !== IDLE_B) begin
      errors++;
      $display("FAIL reset_beat got=%h exp=%h", beat_now(), IDLE_B);
    end
    checks++;
    if (frame_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", frame_cnt_o);
    end
    tx_reset = 1'b0;
    push_idle(6);
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL idle_no_en got=%h exp=%h", beat_now(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge tx_clk);
    end
  endtask

  task automatic test_basic();
    int n;
    n = 0;
    en_i = 1'b1;
    cfg_len_i = 11'd64;
    cfg_err_i = 1'b0;
    do_reset();
    push_idle(2);
    push_frame(64, 1'b0);
    push_idle(2);
    push_frame(5, 1'b1);
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      if (n == 5) begin
        cfg_len_i = 11'd5;
        cfg_err_i = 1'b1;
      end
      if (n == 3) begin
        checks++;
        if (pcs_tx_data_o !== 64'h0706050403020100) begin
          errors++;
          $display("FAIL basic_first_data got=%h exp=0706050403020100",
                   pcs_tx_data_o);
        end
      end
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL basic beat=%0d got=%h exp=%h", n, beat_now(), sb[0]);
      end
      void'(sb.pop_front());
      n++;
      @(negedge tx_clk);
    end
    checks++;
    if (sb.size() != 0 || frame_cnt_o !== 32'(m_cnt)) begin
      errors++;
      $display("FAIL basic_cnt got=%0d exp=%0d left=%0d",
               frame_cnt_o, m_cnt, sb.size());
    end
  endtask

  task automatic test_short(input int len, input bit e);
    int n;
    n = 0;
    en_i = 1'b1;
    cfg_len_i = 11'(len);
    cfg_err_i = e;
    do_reset();
    push_idle(2);
    push_frame(len, e);
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL short L=%0d beat=%0d got=%h exp=%h",
                 len, n, beat_now(), sb[0]);
      end
      void'(sb.pop_front());
      n++;
      @(negedge tx_clk);
    end
    checks++;
    if (sb.size() != 0 || frame_cnt_o !== 32'(m_cnt)) begin
      errors++;
      $display("FAIL short_cnt L=%0d got=%0d exp=%0d", len, frame_cnt_o, m_cnt);
    end
  endtask

  task automatic test_ready_stall();
    int n;
    int stall;
    bit did4;
    bit did8;
    n = 0;
    stall = 0;
    did4 = 1'b0;
    did8 = 1'b0;
    en_i = 1'b1;
    cfg_len_i = 11'd24;
    cfg_err_i = 1'b0;
    do_reset();
    push_idle(2);
    push_frame(24, 1'b0);
    push_idle(2);
    push_frame(24, 1'b0);
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      if (!did4 && n == 4) begin stall = 3; did4 = 1'b1; end
      if (!did8 && n == 8) begin stall = 3; did8 = 1'b1; end
      pcs_tx_ready_i = (stall == 0);
      if (stall > 0) stall--;
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL stall beat=%0d ready=%0b got=%h exp=%h",
                 n, pcs_tx_ready_i, beat_now(), sb[0]);
      end
      if (pcs_tx_ready_i) begin
        void'(sb.pop_front());
        n++;
      end
      @(negedge tx_clk);
    end
    pcs_tx_ready_i = 1'b1;
    checks++;
    if (sb.size() != 0 || frame_cnt_o !== 32'(m_cnt)) begin
      errors++;
      $display("FAIL stall_cnt got=%0d exp=%0d", frame_cnt_o, m_cnt);
    end
  endtask

  task automatic test_en_drop();
    int n;
    n = 0;
    en_i = 1'b1;
    cfg_len_i = 11'd64;
    cfg_err_i = 1'b0;
    do_reset();
    push_idle(2);
    push_frame(64, 1'b0);
    push_idle(12);
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      if (n == 5) en_i = 1'b0;
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL en_drop beat=%0d got=%h exp=%h", n, beat_now(), sb[0]);
      end
      void'(sb.pop_front());
      n++;
      @(negedge tx_clk);
    end
    checks++;
    if (sb.size() != 0 || frame_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL en_drop_cnt got=%0d exp=1", frame_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    en_i = 1'b1;
    cfg_len_i = 11'd16;
    cfg_err_i = 1'b0;
    do_reset();
    push_idle(2);
    push_frame(16, 1'b0);
    push_idle(2);
    push_frame(16, 1'b0);
    for (int c = 0; c < 100 && sb.size() > 0 && n < 10; c++) begin
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL rst_mid beat=%0d got=%h exp=%h", n, beat_now(), sb[0]);
      end
      void'(sb.pop_front());
      n++;
      @(negedge tx_clk);
    end
    checks++;
    if (frame_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL rst_mid_pre_cnt got=%0d exp=1", frame_cnt_o);
    end
    tx_reset = 1'b1;
    @(negedge tx_clk);
    checks++;
    if (beat_now() !== IDLE_B || frame_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_clear got=%h cnt=%0d exp=%h cnt=0",
               beat_now(), frame_cnt_o, IDLE_B);
    end
    tx_reset = 1'b0;
    sb.delete();
    m_seed = '0;
    m_cnt = 0;
    push_idle(2);
    push_frame(16, 1'b0);
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      checks++;
      if (beat_now() !== sb[0]) begin
        errors++;
        $display("FAIL rst_mid_after got=%h exp=%h", beat_now(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge tx_clk);
    end
    checks++;
    if (sb.size() != 0 || frame_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL rst_mid_cnt got=%0d exp=1", frame_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short(13, 1'b1);
    test_short(0, 1'b0);
    test_short(7, 1'b0);
    test_short(8, 1'b1);
    test_ready_stall();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcs_tx_pkt_gen.md
Name: pcs_tx_pkt_gen

Overview:
- Single-lane traffic source driving the TX PCS input interface (ctrl/idle/term/err/start/data/keep) with back-to-back Ethernet frames for FPGA link bring-up.
- Sits in the tx_clk domain, in place of the RX->TX loopback path.
- Emits a deterministic payload so that a far-end checker can verify every byte.

Parameters:
- DATA_W, 64, data width; only 64 is supported, KEEP_W = DATA_W/8.
- LANE0_CNT_N, 2, start-position vector width; the generator only ever uses bit 0 (byte 0).
- IFG_BEATS, 2, idle beats inserted between TERM and the next START; minimum 1.
- LEN_W, 11, payload length field width.

Ports:
- tx_clk  in  1  clock.
- tx_reset  in  1  synchronous, active-high reset.
- en_i  in  1  generation enable; sampled only in IDLE.
- cfg_len_i  in  LEN_W  payload bytes L; latched at START.
- cfg_err_i  in  1  error inject; latched at START.
- pcs_tx_ready_i  in  1  PCS/gearbox accepts the current beat when high.
- pcs_tx_ctrl_o  out  1  control beat.
- pcs_tx_idle_o  out  1  idle beat.
- pcs_tx_term_o  out  1  terminate beat.
- pcs_tx_err_o  out  1  error on terminate beat.
- pcs_tx_start_o  out  LANE0_CNT_N  start position, one-hot.
- pcs_tx_data_o  out  DATA_W  data, byte 0 in bits [7:0].
- pcs_tx_keep_o  out  KEEP_W  valid-byte mask.
- frame_cnt_o  out  32  completed frames; wraps.

Behaviour:
- All outputs are registered.
- Reset values: ctrl=1, idle=1, term=0, err=0, start=0, data=0, keep=0, frame_cnt=0, state=IDLE, gap counter=IFG_BEATS, seed=0.
- Beat accepted = any cycle with pcs_tx_ready_i=1.
- When ready=0: every output holds its value and no state, counter, seed or latched config changes. A ready drop never corrupts or duplicates a beat.
- States, advancing only on an accepted beat:
  - IDLE: output is an idle beat (ctrl=1, idle=1, keep=0, data=0). Gap counter decrements while non-zero. When gap=0 and en_i=1, the next beat is START; otherwise stay in IDLE.
  - START: ctrl=1, start=2'b01, data=64'hD555_5555_5555_55FB, keep=all ones. Latch L=cfg_len_i and E=cfg_err_i; byte index k=0. Next state is DATA if L>=8, else TERM.
  - DATA: ctrl=0, keep=all ones; byte j = (seed+k+j) mod 256 for j=0..7; k+=8. Stay in DATA while L-k>=8 after the increment, else go to TERM.
  - TERM: ctrl=1, term=1, err=E; r=L-k (0..7); keep=(1<<r)-1; bytes j<r follow the payload pattern, bytes j>=r are 0. On acceptance: frame_cnt+1, seed+1 (mod 256), gap counter=IFG_BEATS, next state IDLE.
- Frame shape: ceil((L+1)/8) post-START beats, i.e. floor(L/8) DATA beats plus one TERM beat. L=0 gives START then TERM with keep=0; L a multiple of 8 gives a TERM with keep=0.
- Exactly IFG_BEATS idle beats (counted as accepted beats) separate TERM from the next START.
- After reset release: IFG_BEATS idle beats, then START if en_i=1.
- en_i falling mid-frame: the frame completes normally; no new START follows. en_i changes outside IDLE are ignored.
- cfg_len_i/cfg_err_i changes mid-frame have no effect on the current frame.
- Reset asserted mid-frame: outputs return to reset values on the next edge; the frame is abandoned, seed and frame_cnt are cleared, and no TERM is emitted.
- frame_cnt wraps from 0xFFFF_FFFF to 0.

Test Plan:
- Reset, then en=1, L=64, ready=1 -> 2 idle, START, 8 DATA (first data 0x0706050403020100), TERM keep=0x00, frame_cnt=1, 2 idle, next START with seed=1 (first data byte 0x01).
- L=13, E=1 -> START, 1 DATA, TERM with keep=0x1F, data bytes 0x08..0x0C, err=1.
- L=0 and L=7 -> START then TERM with keep=0x00 and 0x7F respectively; no DATA beat.
- Toggle ready low for 3 cycles during DATA and during the gap -> outputs frozen, no lost or duplicate beat, gap still exactly 2 accepted idle beats.
- Drop en mid-DATA of an L=64 frame -> frame completes with TERM, then idle indefinitely; frame_cnt increments once.
- Assert reset during DATA -> next cycle ctrl=1, idle=1, keep=0, frame_cnt=0; after release 2 idle beats, then START with seed=0.
